// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// frame_buffer : double-buffered 3-bit RGB pixel store for the scanned LED matrix
// Revision     : 1.0
// ============================================================================
module frame_buffer #(
  parameter int NUM_PANELS = 4,
  parameter int HALF_ROWS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] row,
  input  logic [7:0] col,
  output logic [2:0] rgb1,
  output logic [2:0] rgb2,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [2:0] wr_rgb,
  output logic       wr_err,
  input  logic       clear_req,
  input  logic       swap_req,
  output logic       busy,
  output logic       swap_done
);

  localparam int              C_COLS  = 32 * NUM_PANELS;
  localparam int              C_DEPTH = HALF_ROWS * C_COLS;
  localparam int              C_AW    = $clog2(C_DEPTH);
  localparam logic [C_AW-1:0] C_LAST  = C_AW'(C_DEPTH - 1);
  localparam logic [2:0]      C_TOP   = 3'(HALF_ROWS - 1);

  typedef enum logic [1:0] {
    S_INIT      = 2'd0,
    S_IDLE      = 2'd1,
    S_CLEAR     = 2'd2,
    S_SWAP_WAIT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_front;
  logic                  w_front_nxt;
  logic                  w_back;
  logic [C_AW-1:0]       r_clr_cnt;
  logic [2:0]            r_prev_row;
  logic                  w_boundary;
  logic                  w_swap_fire;
  logic                  w_clearing;
  logic                  w_clr_last;
  logic                  w_accept;
  logic                  w_wr_oob;
  logic                  w_col_ok;
  logic [C_AW-1:0]       w_rd_idx;
  logic [C_AW-1:0]       w_wr_idx;
  logic [C_AW-1:0]       w_mem_idx;
  logic [2:0]            w_mem_data;
  logic [1:0][1:0]       w_we;
  logic [1:0][1:0][2:0]  w_rd;

  assign w_back      = ~r_front;
  assign w_boundary  = (row == 3'd0) && (r_prev_row == C_TOP);
  assign w_clearing  = (r_state == S_INIT) || (r_state == S_CLEAR);
  assign w_clr_last  = (r_clr_cnt == C_LAST);
  assign w_front_nxt = r_front ^ w_swap_fire;

  assign busy      = (r_state != S_IDLE);
  assign swap_done = w_swap_fire & ~rst;
  assign wr_ready  = (r_state == S_IDLE) & ~clear_req & ~swap_req & ~rst;
  assign w_accept  = wr_valid & wr_ready;
  assign w_wr_oob  = (int'(wr_x) >= C_COLS);
  assign w_col_ok  = (int'(col) < C_COLS);

  assign w_rd_idx = C_AW'(int'(row) * C_COLS + int'(col));
  assign w_wr_idx = C_AW'(int'(wr_y[2:0]) * C_COLS + int'(wr_x));

  always_comb begin
    w_state_nxt = r_state;
    w_swap_fire = 1'b0;
    case (r_state)
      S_INIT: begin
        if (w_clr_last) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req)     w_state_nxt = S_CLEAR;
        else if (swap_req) w_state_nxt = S_SWAP_WAIT;
      end
      S_CLEAR: begin
        if (w_clr_last) w_state_nxt = S_IDLE;
      end
      S_SWAP_WAIT: begin
        if (w_boundary) begin
          w_state_nxt = S_IDLE;
          w_swap_fire = 1'b1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Clears share the write port with pixel writes; clearing states never accept writes.
  always_comb begin
    w_we       = '0;
    w_mem_idx  = r_clr_cnt;
    w_mem_data = '0;
    case (r_state)
      S_INIT:  w_we = '1;
      S_CLEAR: w_we[w_back] = 2'b11;
      S_IDLE: begin
        if (w_accept && !w_wr_oob) begin
          w_mem_idx              = w_wr_idx;
          w_mem_data             = wr_rgb;
          w_we[w_back][wr_y[3]]  = 1'b1;
        end
      end
      default: w_we = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_front    <= 1'b0;
      r_clr_cnt  <= '0;
      r_prev_row <= 3'd0;
      wr_err     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_front    <= w_front_nxt;
      r_clr_cnt  <= (w_clearing && !w_clr_last) ? r_clr_cnt + 1'b1 : '0;
      r_prev_row <= row;
      wr_err     <= w_accept & w_wr_oob;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic [2:0] r_mem [C_DEPTH];

      always_ff @(posedge clk) begin
        if (w_we[b][h]) r_mem[w_mem_idx] <= w_mem_data;
      end

      assign w_rd[b][h] = r_mem[w_rd_idx];
    end
  end

  // Reads select the next-cycle front so the boundary-cycle read already sees the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb1 <= 3'd0;
      rgb2 <= 3'd0;
    end else if (w_col_ok) begin
      rgb1 <= w_rd[w_front_nxt][0];
      rgb2 <= w_rd[w_front_nxt][1];
    end else begin
      rgb1 <= 3'd0;
      rgb2 <= 3'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_frame_buffer : directed self-checking bench for frame_buffer
// Revision        : 1.0
// ============================================================================
module tb_frame_buffer;

  localparam int COLS   = 128;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] row = 3'd0;
  logic [7:0] col = 8'd0;
  logic [2:0] rgb1;
  logic [2:0] rgb2;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = 8'd0;
  logic [3:0] wr_y = 4'd0;
  logic [2:0] wr_rgb = 3'd0;
  logic       wr_err;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       busy;
  logic       swap_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] mdl [2][16][COLS];
  int         mfront = 0;

  frame_buffer #(.NUM_PANELS(4), .HALF_ROWS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .rgb1      (rgb1),
    .rgb2      (rgb2),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_rgb    (wr_rgb),
    .wr_err    (wr_err),
    .clear_req (clear_req),
    .swap_req  (swap_req),
    .busy      (busy),
    .swap_done (swap_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_bank(input int b);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < COLS; x++)
        mdl[b][y][x] = 3'd0;
  endtask

  task automatic model_write(input int x, input int y, input logic [2:0] v);
    if (x < COLS) mdl[1 - mfront][y][x] = v;
  endtask

  task automatic read_px(input int r, input int c, output logic [2:0] o1, output logic [2:0] o2);
    row = 3'(r);
    col = 8'(c);
    tick();
    o1 = rgb1;
    o2 = rgb2;
  endtask

  task automatic scan(output int bad);
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < COLS; c++) begin
        row = 3'(r);
        col = 8'(c);
        tick();
        if (rgb1 !== mdl[mfront][r][c])     bad++;
        if (rgb2 !== mdl[mfront][r + 8][c]) bad++;
      end
    end
  endtask

  task automatic write_px(input int x, input int y, input logic [2:0] v, output bit rdy);
    wr_x     = 8'(x);
    wr_y     = 4'(y);
    wr_rgb   = v;
    wr_valid = 1'b1;
    #1;
    rdy = wr_ready;
    tick();
    wr_valid = 1'b0;
  endtask

  // Two full frames of rows 0..7: exactly one 7->0 boundary when starting from row 0.
  task automatic run_frames(output int pulses);
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 8; r++) begin
        row = 3'(r);
        col = 8'd0;
        #1;
        if (swap_done === 1'b1) pulses++;
        tick();
      end
    end
  endtask

  task automatic run_swap(output int pulses);
    row      = 3'd0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_frames(pulses);
    mfront = 1 - mfront;
  endtask

  task automatic count_busy(output int n, output int pulses);
    n      = 0;
    pulses = 0;
    while (busy === 1'b1 && n < BUDGET) begin
      if (swap_done === 1'b1) pulses++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, p, bad;
    rst = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || wr_err !== 1'b0 || swap_done !== 1'b0 ||
        rgb1 !== 3'd0 || rgb2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b wr_ready=%b wr_err=%b swap_done=%b rgb1=%b rgb2=%b, want 1 0 0 0 000 000",
               busy, wr_ready, wr_err, swap_done, rgb1, rgb2);
    end
    rst = 1'b0;
    count_busy(n, p);
    n_tests++;
    if (n !== 1024) begin
      n_fail++;
      $display("FAIL init_length: busy cycles=%0d, want 1024", n);
    end
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: wr_ready=%b, want 1", wr_ready);
    end
    model_clear_bank(0);
    model_clear_bank(1);
    mfront = 0;
    scan(bad);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_scan: %0d nonzero pixels, want 0", bad);
    end
  endtask

  task automatic test_write_swap();
    bit rdy;
    int p, bad;
    logic [2:0] o1, o2;
    write_px(5, 2, 3'b101, rdy);
    model_write(5, 2, 3'b101);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready_a: wr_ready=%b, want 1", rdy);
    end
    write_px(127, 10, 3'b011, rdy);
    model_write(127, 10, 3'b011);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready_b: wr_ready=%b, want 1", rdy);
    end
    run_swap(p);
    n_tests++;
    if (p !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pulse: pulses=%0d busy=%b, want 1 and 0", p, busy);
    end
    read_px(2, 5, o1, o2);
    n_tests++;
    if (o1 !== 3'b101) begin
      n_fail++;
      $display("FAIL read_5_2: rgb1=%b, want 101", o1);
    end
    read_px(2, 127, o1, o2);
    n_tests++;
    if (o2 !== 3'b011) begin
      n_fail++;
      $display("FAIL read_127_10: rgb2=%b, want 011", o2);
    end
    scan(bad);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL scan_after_swap: %0d bad pixels, want 0", bad);
    end
  endtask

  task automatic test_wr_err();
    bit rdy;
    int p, bad;
    logic [2:0] o1, o2;
    write_px(10, 0, 3'b001, rdy);
    model_write(10, 0, 3'b001);
    write_px(200, 3, 3'b111, rdy);
    n_tests++;
    if (rdy !== 1'b1 || wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_accept: wr_ready=%b wr_err=%b, want 1 1", rdy, wr_err);
    end
    tick();
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_pulse_width: wr_err=%b, want 0", wr_err);
    end
    run_swap(p);
    n_tests++;
    if (p !== 1) begin
      n_fail++;
      $display("FAIL oob_swap: pulses=%0d, want 1", p);
    end
    read_px(3, 200, o1, o2);
    n_tests++;
    if (o1 !== 3'd0 || o2 !== 3'd0) begin
      n_fail++;
      $display("FAIL oob_col_read: rgb1=%b rgb2=%b, want 000 000", o1, o2);
    end
    scan(bad);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL oob_scan: %0d bad pixels, want 0", bad);
    end
  endtask

  task automatic test_clear_swap();
    int n, p, bad;
    clear_req = 1'b1;
    swap_req  = 1'b1;
    #1;
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: wr_ready=%b, want 0", wr_ready);
    end
    tick();
    clear_req = 1'b0;
    swap_req  = 1'b0;
    count_busy(n, p);
    n_tests++;
    if (n !== 1024 || p !== 0) begin
      n_fail++;
      $display("FAIL clear_length: busy cycles=%0d swap pulses=%0d, want 1024 0", n, p);
    end
    model_clear_bank(1 - mfront);
    run_frames(p);
    n_tests++;
    if (p !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_swap: pulses=%0d busy=%b, want 0 0", p, busy);
    end
    scan(bad);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clear_front_kept: %0d bad pixels, want 0", bad);
    end
    run_swap(p);
    scan(bad);
    n_tests++;
    if (p !== 1 || bad !== 0) begin
      n_fail++;
      $display("FAIL cleared_back: pulses=%0d bad pixels=%0d, want 1 0", p, bad);
    end
  endtask

  task automatic test_swap_wait_writes();
    int bad_rdy, bad_px;
    row      = 3'd0;
    col      = 8'd10;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    bad_rdy  = 0;
    bad_px   = 0;
    wr_x     = 8'd10;
    wr_y     = 4'd0;
    wr_rgb   = 3'b111;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (wr_ready !== 1'b0) bad_rdy++;
      tick();
      if (rgb1 !== mdl[mfront][0][10]) bad_px++;
    end
    wr_valid = 1'b0;
    n_tests++;
    if (bad_rdy !== 0 || bad_px !== 0) begin
      n_fail++;
      $display("FAIL swap_wait_hold: ready-high cycles=%0d changed reads=%0d, want 0 0", bad_rdy, bad_px);
    end
    for (int r = 1; r < 8; r++) begin
      row = 3'(r);
      tick();
    end
    row = 3'd0;
    #1;
    n_tests++;
    if (swap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_pulse: swap_done=%b, want 1", swap_done);
    end
    tick();
    mfront = 1 - mfront;
    n_tests++;
    if (rgb1 !== 3'b001 || swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_read: rgb1=%b swap_done=%b, want 001 0", rgb1, swap_done);
    end
  endtask

  task automatic test_reset_mid_swap();
    bit rdy;
    int n, p, bad;
    logic [2:0] o1, o2;
    write_px(3, 4, 3'b010, rdy);
    model_write(3, 4, 3'b010);
    run_swap(p);
    read_px(4, 3, o1, o2);
    n_tests++;
    if (p !== 1 || o1 !== 3'b010) begin
      n_fail++;
      $display("FAIL pre_reset_swap: pulses=%0d rgb1=%b, want 1 010", p, o1);
    end
    row      = 3'd0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    row      = 3'd7;
    tick();
    row = 3'd0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: swap_done=%b, want 0", swap_done);
    end
    tick();
    rst = 1'b0;
    count_busy(n, p);
    n_tests++;
    if (n !== 1024 || p !== 0) begin
      n_fail++;
      $display("FAIL reinit_length: busy cycles=%0d pulses=%0d, want 1024 0", n, p);
    end
    model_clear_bank(0);
    model_clear_bank(1);
    mfront = 0;
    run_frames(p);
    n_tests++;
    if (p !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_discarded: pulses=%0d busy=%b, want 0 0", p, busy);
    end
    scan(bad);
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reinit_scan: %0d nonzero pixels, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_wr_err();
    test_clear_swap();
    test_swap_wait_writes();
    test_reset_mid_swap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered RGB pixel store for the 16-row x (32*NUM_PANELS)-column LED matrix, 3-bit colour per pixel.
- Read side is driven by the scan sequencer's row/col and produces rgb1 (upper half) and rgb2 (lower half). It replaces the procedural pixel generator in the display path.
- Write side is a valid/ready pixel port into the back buffer, plus clear and frame-synchronous swap commands.

Parameters:
- NUM_PANELS, 4, panels in series; COLS = 32*NUM_PANELS (derived, not overridable).
- HALF_ROWS, 8, scan rows per half; the panel has 2*HALF_ROWS rows.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row  in  3  scan row from sequencer.
- col  in  8  scan column from sequencer.
- rgb1  out  3  pixel (col, row) of front buffer; registered.
- rgb2  out  3  pixel (col, row+HALF_ROWS) of front buffer; registered.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_x  in  8  write column.
- wr_y  in  4  write row 0..15.
- wr_rgb  in  3  write colour.
- wr_err  out  1  one-cycle pulse: accepted write had wr_x >= COLS; the write is dropped.
- clear_req  in  1  clear back buffer; sampled only in IDLE.
- swap_req  in  1  swap front/back at next frame boundary; sampled only in IDLE.
- busy  out  1  state != IDLE.
- swap_done  out  1  one-cycle pulse when the swap takes effect.

Behaviour:
- Storage: 4 arrays (bank 0/1 x upper/lower half), each HALF_ROWS*COLS entries of 3 bits.
  - Index = y[2:0]*COLS + x; y[3] selects the half.
  - front: 1-bit bank select. back = ~front.
- Read path:
  - rgb1/rgb2 are registered with 1-cycle latency from row/col. The sequencer presents col one cycle ahead of its shift-out.
  - If col >= COLS, rgb1 = rgb2 = 0 on the next cycle.
- Frame boundary: the cycle where row==0 and prev_row==HALF_ROWS-1. prev_row is row registered each cycle and reset to 0, so reset never creates a false boundary.
- States:
  - INIT (entered on reset): clears both banks, both halves, one index per cycle, for HALF_ROWS*COLS cycles (1024 at defaults). Then goes to IDLE.
  - IDLE: priority is clear_req > swap_req > writes.
    - clear_req -> CLEAR, clearing the back bank only, same cycle count as INIT, then IDLE.
    - swap_req -> SWAP_WAIT.
  - SWAP_WAIT: on a boundary cycle, front toggles at the next edge, state -> IDLE, and swap_done = 1 for that single cycle.
    - The read issued in the boundary cycle already uses the new front bank (read select = next-front).
- Command sampling: requests seen outside IDLE are ignored. Requesters hold their request until busy rises.
- Writes:
  - wr_ready = (state==IDLE) & ~clear_req & ~swap_req.
  - An accepted write updates the back bank at the next edge.
  - wr_x >= COLS: the write is accepted (ready honoured), memory is unchanged, and wr_err pulses the following cycle.
  - Writes never touch the front bank. Reads and writes to the same coordinate never conflict, because they target different banks.
- Reset values: rgb1 = rgb2 = 0, wr_ready = 0, wr_err = 0, swap_done = 0, busy = 1 (INIT), front = 0, clear counter = 0.
- Reset mid-operation:
  - rst in any state aborts it, returns to INIT and restarts the full clear.
  - A pending swap is discarded and front returns to 0.
- Clear counter: 10 bits at defaults, sized clog2(HALF_ROWS*COLS). Terminal count = HALF_ROWS*COLS-1; the state exits on the cycle after the last write.

Test Plan:
- Reset held 1 cycle, then released -> busy=1 for exactly 1024 cycles, then busy=0 and wr_ready=1. A full scan of all row/col reads rgb1 = rgb2 = 0.
- Write (x=5, y=2, rgb=3'b101) and (x=127, y=10, rgb=3'b011), then swap_req, with the sequencer cycling rows 7->0 -> swap_done pulses once at the boundary. Next frame: col=5/row=2 gives rgb1=101 one cycle later; col=127/row=2 gives rgb2=011. All other pixels read 0.
- Write with wr_x=200 -> accepted, wr_err=1 for one cycle. After a swap, col=200 reads 0 and no other pixel changed.
- clear_req and swap_req asserted together in IDLE -> CLEAR runs for 1024 cycles, swap is not taken, and swap_done stays 0. Back bank reads all-zero after a later swap.
- Writes attempted during SWAP_WAIT -> wr_ready=0. The displayed front data stays constant until the boundary.
- rst asserted during SWAP_WAIT after front=1 -> front=0, INIT re-runs for 1024 cycles, and no swap_done pulse is produced.
